// File: rtl/dr_pkg.sv
// Shared types and constants for the DR bus sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LATCH,
        ST_HOLD,
        ST_DONE
    } state_t;

    // Bit of the captured byte that routes it to the command output
    localparam int   CMD_BIT       = 7;
    // Level at which EDR/ECR enable the DR outputs
    localparam logic OE_ACTIVE_LOW = 1'b0;
    // Width of the hold counter, covers HOLD_CYCLES up to 15
    localparam int   HOLD_W        = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester after ptr, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; en=0 forces gnt=0 and vld=0.
// Ports: req (request vector), ptr (index of last grant), en (grant enable),
//        gnt (one-hot winner), vld (a winner exists).
module rr_arbiter #(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0]                       req,
    input  logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] ptr,
    input  logic                                   en,
    output logic [N_REQ-1:0]                       gnt,
    output logic                                   vld
);

    always_comb begin
        gnt = '0;
        vld = 1'b0;
        if (en) begin
            // First pass: lowest requester strictly above the pointer
            for (int i = 0; i < N_REQ; i++) begin
                if (!vld && req[i] && (i > int'(ptr))) begin
                    gnt[i] = 1'b1;
                    vld    = 1'b1;
                end
            end
            // Second pass: wrap around, lowest index wins
            for (int i = 0; i < N_REQ; i++) begin
                if (!vld && req[i]) begin
                    gnt[i] = 1'b1;
                    vld    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dr_bus_sequencer.sv
// Arbitrates N_REQ requesters onto the DR write path and sequences IDR/EDR/ECR/EAR.
// Latency: grant registered one cycle after REQ is sampled; one transfer every 3+HOLD_CYCLES cycles.
// Backpressure: requests wait (level REQ) until the FSM is IDLE or DONE and they win round-robin.
// Ports: CLK/RST; REQ, DIN, ADDR per requester; GNT, DONE, BUSY status;
//        DBUS/DBUS_OE data path; IDR, EDR, ECR, EAR DR strobes. All outputs registered.
module dr_bus_sequencer
    import dr_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int HOLD_CYCLES = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N_REQ-1:0]   REQ,
    input  logic [8*N_REQ-1:0] DIN,
    input  logic [N_REQ-1:0]   ADDR,
    output logic [N_REQ-1:0]   GNT,
    output logic               DONE,
    output logic               BUSY,
    output logic [7:0]         DBUS,
    output logic               DBUS_OE,
    output logic               IDR,
    output logic               EDR,
    output logic               ECR,
    output logic               EAR
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t            state_q, state_nxt;
    logic [PW-1:0]     ptr_q;
    logic [HOLD_W-1:0] cnt_q;
    logic              addr_q;

    logic              arb_en;
    logic [N_REQ-1:0]  win;
    logic              win_vld;
    logic [7:0]        win_din;
    logic              win_addr;
    logic [PW-1:0]     win_idx;

    logic [7:0]        dbus_d;
    logic              addr_d;
    logic [N_REQ-1:0]  gnt_d;
    logic              done_d, busy_d, oe_d, idr_d, edr_d, ecr_d, ear_d;

    assign arb_en = (state_q == ST_IDLE) || (state_q == ST_DONE);

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req (REQ),
        .ptr (ptr_q),
        .en  (arb_en),
        .gnt (win),
        .vld (win_vld)
    );

    // Winner's byte, address flag and index
    always_comb begin
        win_din  = '0;
        win_addr = 1'b0;
        win_idx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) begin
                win_din  = DIN[8*i +: 8];
                win_addr = ADDR[i];
                win_idx  = PW'(i);
            end
        end
    end

    // Capture happens only on a grant; otherwise the transfer keeps its own copy
    assign dbus_d = win_vld ? win_din  : DBUS;
    assign addr_d = win_vld ? win_addr : addr_q;

    // State register plus capture, pointer and hold counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            ptr_q   <= PW'(N_REQ - 1);
            cnt_q   <= '0;
            addr_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            addr_q  <= addr_d;
            if (win_vld) begin
                ptr_q <= win_idx;
            end
            if (state_q == ST_LATCH) begin
                cnt_q <= HOLD_W'(HOLD_CYCLES - 1);
            end else if ((state_q == ST_HOLD) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: state_nxt = win_vld ? ST_SETUP : ST_IDLE;
            ST_SETUP:         state_nxt = ST_LATCH;
            ST_LATCH:         state_nxt = ST_HOLD;
            ST_HOLD:          if (cnt_q == '0) state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the next state so every output leaves a flop
    always_comb begin
        gnt_d  = win;
        done_d = 1'b0;
        busy_d = (state_nxt != ST_IDLE);
        oe_d   = 1'b0;
        idr_d  = 1'b0;
        edr_d  = ~OE_ACTIVE_LOW;
        ecr_d  = ~OE_ACTIVE_LOW;
        ear_d  = 1'b0;
        case (state_nxt)
            ST_SETUP: oe_d = 1'b1;
            ST_LATCH: begin
                oe_d  = 1'b1;
                idr_d = 1'b1;
            end
            ST_HOLD: begin
                // Captured byte's top bit selects command vs data output
                if (dbus_d[CMD_BIT]) begin
                    ecr_d = OE_ACTIVE_LOW;
                end else begin
                    edr_d = OE_ACTIVE_LOW;
                end
                ear_d = addr_d;
            end
            ST_DONE:  done_d = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            GNT     <= '0;
            DONE    <= 1'b0;
            BUSY    <= 1'b0;
            DBUS    <= 8'h00;
            DBUS_OE <= 1'b0;
            IDR     <= 1'b0;
            EDR     <= ~OE_ACTIVE_LOW;
            ECR     <= ~OE_ACTIVE_LOW;
            EAR     <= 1'b0;
        end else begin
            GNT     <= gnt_d;
            DONE    <= done_d;
            BUSY    <= busy_d;
            DBUS    <= dbus_d;
            DBUS_OE <= oe_d;
            IDR     <= idr_d;
            EDR     <= edr_d;
            ECR     <= ecr_d;
            EAR     <= ear_d;
        end
    end

endmodule

// File: tb/tb_dr_bus_sequencer.sv
// Scoreboard bench for dr_bus_sequencer: stimulus pushes expected events, monitor checks them.
// Latency: expects GNT->IDR 1 cycle, GNT->DONE 2+H cycles, grant period 3+H back to back.
// Backpressure: n/a.
module tb_dr_bus_sequencer;

    localparam int N = 3;
    localparam int H = 2;

    logic           CLK = 1'b0;
    logic           RST;
    logic [N-1:0]   REQ;
    logic [8*N-1:0] DIN;
    logic [N-1:0]   ADDR;
    logic [N-1:0]   GNT;
    logic           DONE, BUSY, DBUS_OE, IDR, EDR, ECR, EAR;
    logic [7:0]     DBUS;

    dr_bus_sequencer #(.N_REQ(N), .HOLD_CYCLES(H)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ     (REQ),
        .DIN     (DIN),
        .ADDR    (ADDR),
        .GNT     (GNT),
        .DONE    (DONE),
        .BUSY    (BUSY),
        .DBUS    (DBUS),
        .DBUS_OE (DBUS_OE),
        .IDR     (IDR),
        .EDR     (EDR),
        .ECR     (ECR),
        .EAR     (EAR)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_err    = 0;

    // Expected-event queues
    logic [N-1:0] q_gnt[$];
    int           q_gap[$];
    logic [7:0]   q_idr[$];
    logic [2:0]   q_hold[$];   // {EDR, ECR, EAR}
    logic [7:0]   q_done[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic unexp(input string nm);
        n_checks++;
        n_err++;
        $display("FAIL %s: event seen with nothing expected", nm);
    endtask

    task automatic push_xfer(input logic [N-1:0] g, input int gap, input logic [7:0] b, input logic a);
        q_gnt.push_back(g);
        q_gap.push_back(gap);
        q_idr.push_back(b);
        for (int i = 0; i < H; i++) begin
            q_hold.push_back(b[7] ? {1'b1, 1'b0, a} : {1'b0, 1'b1, a});
        end
        q_done.push_back(b);
    endtask

    // Monitor
    int cyc = 0;
    int last_gnt = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (!RST) begin
            if (GNT != '0) begin
                if (q_gnt.size() == 0) unexp("gnt");
                else begin
                    logic [N-1:0] eg;
                    int           gp;
                    eg = q_gnt.pop_front();
                    gp = q_gap.pop_front();
                    chk("gnt", {BUSY, GNT}, {1'b1, eg});
                    if (gp != 0) chk("gnt_period", cyc - last_gnt, gp);
                end
                last_gnt <= cyc;
            end
            if (IDR) begin
                if (q_idr.size() == 0) unexp("idr");
                else begin
                    chk("idr_bus", {DBUS, DBUS_OE, EDR, ECR, EAR}, {q_idr.pop_front(), 1'b1, 1'b1, 1'b1, 1'b0});
                    chk("idr_latency", cyc - last_gnt, 1);
                end
            end
            if (!EDR || !ECR || EAR) begin
                if (q_hold.size() == 0) unexp("hold");
                else chk("hold", {DBUS_OE, EDR, ECR, EAR}, {1'b0, q_hold.pop_front()});
            end
            if (DONE) begin
                if (q_done.size() == 0) unexp("done");
                else begin
                    chk("done", {DBUS, BUSY, DBUS_OE, IDR, EDR, ECR, EAR},
                        {q_done.pop_front(), 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
                    chk("done_latency", cyc - last_gnt, 2 + H);
                end
            end
        end
    end

    task automatic wait_gnt(input int n);
        int seen;
        seen = 0;
        for (int c = 0; c < 200 && seen < n; c++) begin
            @(negedge CLK);
            if (GNT != '0) seen++;
        end
        if (seen < n) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_gnt: got %0d grants, required %0d", seen, n);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge CLK);
            if (!BUSY) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_idle: BUSY still 1, required 0");
        end
    endtask

    task automatic chk_reset(input string nm);
        chk(nm, {GNT, DONE, BUSY, DBUS_OE, IDR, EDR, ECR, EAR},
            {3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        chk({nm, "_dbus"}, {24'h0, DBUS}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen_hold;
        RST  = 1'b0;
        REQ  = '0;
        DIN  = '0;
        ADDR = '0;

        // Reset pulse mid-cycle, checked before the next edge
        #2 RST = 1'b1;
        #1 chk_reset("reset_async");
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // Single data transfer from requester 0
        DIN[7:0] = 8'h25;
        push_xfer(3'b001, 0, 8'h25, 1'b0);
        REQ = 3'b001;
        wait_gnt(1);
        REQ = '0;
        wait_idle();

        // Command byte with address from requester 1
        DIN[15:8] = 8'h83;
        ADDR      = 3'b010;
        push_xfer(3'b010, 0, 8'h83, 1'b1);
        REQ = 3'b010;
        wait_gnt(1);
        REQ  = '0;
        ADDR = '0;
        wait_idle();

        // Fresh reset so the pointer starts at N-1
        @(negedge CLK);
        #1 RST = 1'b1;
        #1 chk_reset("reset_again");
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // Round-robin, all requesting, back-to-back grants every 3+H cycles
        DIN  = {8'hC4, 8'h83, 8'h25};
        ADDR = 3'b010;
        push_xfer(3'b001, 0,     8'h25, 1'b0);
        push_xfer(3'b010, 3 + H, 8'h83, 1'b1);
        push_xfer(3'b100, 3 + H, 8'hC4, 1'b0);
        push_xfer(3'b001, 3 + H, 8'h25, 1'b0);
        REQ = 3'b111;
        wait_gnt(4);
        REQ  = '0;
        ADDR = '0;
        wait_idle();

        // Request dropped and data changed right after the grant
        DIN[7:0] = 8'h5A;
        push_xfer(3'b001, 0, 8'h5A, 1'b0);
        REQ = 3'b001;
        wait_gnt(1);
        REQ      = '0;
        DIN[7:0] = 8'hFF;
        wait_idle();

        // Reset during HOLD: only the first hold cycle is expected, no DONE
        DIN[7:0] = 8'h11;
        q_gnt.push_back(3'b001);
        q_gap.push_back(0);
        q_idr.push_back(8'h11);
        q_hold.push_back(3'b010);
        REQ = 3'b001;
        wait_gnt(1);
        REQ = '0;
        seen_hold = 1'b0;
        for (int c = 0; c < 10 && !seen_hold; c++) begin
            @(negedge CLK);
            if (!EDR) seen_hold = 1'b1;
        end
        chk("reach_hold", {31'h0, seen_hold}, 32'h1);
        #1 RST = 1'b1;
        #1 chk_reset("reset_in_hold");
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // Pointer back at N-1: index 0 beats index 1
        DIN[7:0] = 8'h36;
        push_xfer(3'b001, 0, 8'h36, 1'b0);
        REQ = 3'b011;
        wait_gnt(1);
        REQ = '0;
        wait_idle();
        repeat (4) @(negedge CLK);

        chk("leftover_events", q_gnt.size() + q_idr.size() + q_hold.size() + q_done.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
